// File: rtl/mrd_pkg.sv
// Shared encodings for the miss-read line server: FSM state codes, owner codes
// and line geometry.
package mrd_pkg;
   localparam logic [2:0] MRS_IDLE = 3'd0;
   localparam logic [2:0] MRS_ISSU = 3'd1;
   localparam logic [2:0] MRS_DRAN = 3'd2;
   localparam logic [2:0] MRS_RESP = 3'd3;
   localparam logic [2:0] MRS_FINS = 3'd4;

   localparam logic OWN_IC = 1'b0;
   localparam logic OWN_DC = 1'b1;

   localparam int MRD_BEATS  = 4;
   localparam int MRD_WORD_W = 32;
   localparam int MRD_LINE_W = MRD_BEATS * MRD_WORD_W;
endpackage

// File: rtl/mrd_req_latch.sv
// One requester's pending flag and latched line index. The index output bypasses
// the register so a request can be granted in the same cycle it is pulsed.
module mrd_req_latch #(
   parameter int AWIDTH = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              active,
   input  logic              grant,
   input  logic [31:0]       addr,
   output logic              pend,
   output logic [AWIDTH-3:0] index
);
   logic              pend_r;
   logic [AWIDTH-3:0] idx_r;
   logic              unused_addr_s;

   assign unused_addr_s = ^{addr[31:AWIDTH+2], addr[3:0]};

   // Pending flag and index register; a re-pulse from the active owner only
   // refreshes the index so it is not serviced a second time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r <= 1'b0;
         idx_r  <= '0;
      end else begin
         if (grant) begin
            pend_r <= 1'b0;
         end else if (start && !active) begin
            pend_r <= 1'b1;
         end else begin
            pend_r <= pend_r;
         end
         if (start) begin
            idx_r <= addr[AWIDTH+1:4];
         end else begin
            idx_r <= idx_r;
         end
      end
   end

   assign pend  = pend_r;
   assign index = start ? addr[AWIDTH+1:4] : idx_r;
endmodule

// File: rtl/mrd_line_server.sv
// Line-read responder for the IC and DC miss controllers: reads four 32-bit beats
// from a synchronous RAM and returns the 128-bit line with valid/finish pulses.
module mrd_line_server
   import mrd_pkg::*;
#(
   parameter int AWIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ic_start_rq,
   input  logic [31:0]           ic_rin_addr,
   input  logic                  dc_start_rq,
   input  logic [31:0]           dc_rin_addr,
   output logic [MRD_LINE_W-1:0] rdat_m_data,
   output logic                  ic_rdat_m_valid,
   output logic                  dc_rdat_m_valid,
   output logic                  ic_finish_mrd,
   output logic                  dc_finish_mrd,
   output logic                  mem_ren,
   output logic [AWIDTH-1:0]     mem_radr,
   input  logic [31:0]           mem_rdata,
   output logic                  busy
);
   logic [2:0]            state_r, state_nx_s;
   logic [1:0]            beat_r, beat_nx_s;
   logic                  owner_r, owner_nx_s;
   logic [AWIDTH-3:0]     idx_r, idx_nx_s;
   logic                  ic_pend_s, dc_pend_s, ic_grant_s, dc_grant_s;
   logic                  ic_active_s, dc_active_s;
   logic [AWIDTH-3:0]     ic_index_s, dc_index_s;
   logic                  busy_r, mem_ren_r, ic_valid_r, dc_valid_r, ic_fin_r, dc_fin_r;
   logic [AWIDTH-1:0]     mem_radr_r;
   logic                  cap_vld_r;
   logic [1:0]            cap_beat_r;
   logic [MRD_LINE_W-1:0] line_r;

   assign ic_active_s = (state_r != MRS_IDLE) && (owner_r == OWN_IC);
   assign dc_active_s = (state_r != MRS_IDLE) && (owner_r == OWN_DC);

   mrd_req_latch #(.AWIDTH(AWIDTH)) u_ic_latch (
      .clk(clk), .rst_n(rst_n), .start(ic_start_rq), .active(ic_active_s),
      .grant(ic_grant_s), .addr(ic_rin_addr), .pend(ic_pend_s), .index(ic_index_s)
   );

   mrd_req_latch #(.AWIDTH(AWIDTH)) u_dc_latch (
      .clk(clk), .rst_n(rst_n), .start(dc_start_rq), .active(dc_active_s),
      .grant(dc_grant_s), .addr(dc_rin_addr), .pend(dc_pend_s), .index(dc_index_s)
   );

   // Arbitration (DC over IC) and next-state/beat/owner selection.
   always_comb begin
      state_nx_s = state_r;
      beat_nx_s  = beat_r;
      owner_nx_s = owner_r;
      idx_nx_s   = idx_r;
      ic_grant_s = 1'b0;
      dc_grant_s = 1'b0;
      case (state_r)
         MRS_IDLE: begin
            if (dc_pend_s || dc_start_rq) begin
               dc_grant_s = 1'b1;
               owner_nx_s = OWN_DC;
               idx_nx_s   = dc_index_s;
               beat_nx_s  = 2'd0;
               state_nx_s = MRS_ISSU;
            end else if (ic_pend_s || ic_start_rq) begin
               ic_grant_s = 1'b1;
               owner_nx_s = OWN_IC;
               idx_nx_s   = ic_index_s;
               beat_nx_s  = 2'd0;
               state_nx_s = MRS_ISSU;
            end else begin
               state_nx_s = MRS_IDLE;
            end
         end
         MRS_ISSU: begin
            if (beat_r == 2'(MRD_BEATS - 1)) begin
               beat_nx_s  = 2'd0;
               state_nx_s = MRS_DRAN;
            end else begin
               beat_nx_s  = beat_r + 2'd1;
            end
         end
         MRS_DRAN: state_nx_s = MRS_RESP;
         MRS_RESP: state_nx_s = MRS_FINS;
         MRS_FINS: state_nx_s = MRS_IDLE;
         default:  state_nx_s = MRS_IDLE;
      endcase
   end

   // State, registered outputs and beat capture into the shared line buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= MRS_IDLE;
         beat_r     <= 2'd0;
         owner_r    <= OWN_IC;
         idx_r      <= '0;
         busy_r     <= 1'b0;
         mem_ren_r  <= 1'b0;
         mem_radr_r <= '0;
         ic_valid_r <= 1'b0;
         dc_valid_r <= 1'b0;
         ic_fin_r   <= 1'b0;
         dc_fin_r   <= 1'b0;
         cap_vld_r  <= 1'b0;
         cap_beat_r <= 2'd0;
         line_r     <= '0;
      end else begin
         state_r    <= state_nx_s;
         beat_r     <= beat_nx_s;
         owner_r    <= owner_nx_s;
         idx_r      <= idx_nx_s;
         busy_r     <= (state_nx_s != MRS_IDLE);
         mem_ren_r  <= (state_nx_s == MRS_ISSU);
         mem_radr_r <= {idx_nx_s, beat_nx_s};
         ic_valid_r <= (state_nx_s == MRS_RESP) && (owner_nx_s == OWN_IC);
         dc_valid_r <= (state_nx_s == MRS_RESP) && (owner_nx_s == OWN_DC);
         ic_fin_r   <= (state_nx_s == MRS_FINS) && (owner_nx_s == OWN_IC);
         dc_fin_r   <= (state_nx_s == MRS_FINS) && (owner_nx_s == OWN_DC);
         // RAM data lags the read enable by one cycle, so capture tracks it.
         cap_vld_r  <= mem_ren_r;
         cap_beat_r <= mem_radr_r[1:0];
         if (cap_vld_r) begin
            line_r[{cap_beat_r, 5'b00000} +: MRD_WORD_W] <= mem_rdata;
         end else begin
            line_r <= line_r;
         end
      end
   end

   assign rdat_m_data     = line_r;
   assign ic_rdat_m_valid = ic_valid_r;
   assign dc_rdat_m_valid = dc_valid_r;
   assign ic_finish_mrd   = ic_fin_r;
   assign dc_finish_mrd   = dc_fin_r;
   assign mem_ren         = mem_ren_r;
   assign mem_radr        = mem_radr_r;
   assign busy            = busy_r;
endmodule

// File: tb/tb_mrd_line_server.sv
// Scoreboard bench for mrd_line_server: stimulus pushes expected addresses and
// responses with their cycle numbers, a negedge monitor pops and compares them.
module tb_mrd_line_server;
   localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] LA = 128'hA3333333_A2222222_A1111111_A0000000;
   localparam logic [127:0] LB = 128'hB0000004_B0000003_B0000002_B0000001;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ic_start_rq, dc_start_rq;
   logic [31:0]  ic_rin_addr, dc_rin_addr;
   logic [127:0] rdat_m_data;
   logic         ic_rdat_m_valid, dc_rdat_m_valid, ic_finish_mrd, dc_finish_mrd;
   logic         mem_ren, busy;
   logic [13:0]  mem_radr;
   logic [31:0]  mem_rdata;

   logic [31:0]  ram [0:16383];
   int           cyc = 0;
   int           n_vec = 0;
   int           n_err = 0;

   typedef struct { logic own; logic [127:0] data; int cyc; } rsp_t;
   typedef struct { logic [13:0] a; int cyc; } adr_t;
   rsp_t rsp_q[$];
   rsp_t fin_q[$];
   adr_t adr_q[$];
   rsp_t mr, mf;
   adr_t ma;

   mrd_line_server #(.AWIDTH(14)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_start_rq(ic_start_rq), .ic_rin_addr(ic_rin_addr),
      .dc_start_rq(dc_start_rq), .dc_rin_addr(dc_rin_addr),
      .rdat_m_data(rdat_m_data),
      .ic_rdat_m_valid(ic_rdat_m_valid), .dc_rdat_m_valid(dc_rdat_m_valid),
      .ic_finish_mrd(ic_finish_mrd), .dc_finish_mrd(dc_finish_mrd),
      .mem_ren(mem_ren), .mem_radr(mem_radr), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= ram[mem_radr];
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_line(input logic own, input logic [13:0] base,
                            input logic [127:0] d, input int t);
      for (int k = 0; k < 4; k++) adr_q.push_back('{a: base + 14'(k), cyc: t + 1 + k});
      rsp_q.push_back('{own: own, data: d, cyc: t + 6});
      fin_q.push_back('{own: own, data: 128'h0, cyc: t + 7});
   endtask

   task automatic pulse(input logic ic, input logic dc, input logic [31:0] ia,
                        input logic [31:0] da, output int t);
      @(posedge clk); #1;
      ic_start_rq = ic; dc_start_rq = dc;
      ic_rin_addr = ia; dc_rin_addr = da;
      t = cyc;
      @(posedge clk); #1;
      ic_start_rq = 1'b0; dc_start_rq = 1'b0;
      ic_rin_addr = 32'h0; dc_rin_addr = 32'h0;
   endtask

   // Monitor: every DUT output event is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_ren) begin
            chk("radr_expected", 128'(adr_q.size() != 0), 128'h1);
            if (adr_q.size() != 0) begin
               ma = adr_q.pop_front();
               chk("mem_radr", 128'(mem_radr), 128'(ma.a));
               chk("radr_cycle", 128'(cyc), 128'(ma.cyc));
            end
         end
         if (ic_rdat_m_valid || dc_rdat_m_valid) begin
            chk("valid_onehot", 128'(ic_rdat_m_valid & dc_rdat_m_valid), 128'h0);
            chk("rsp_expected", 128'(rsp_q.size() != 0), 128'h1);
            if (rsp_q.size() != 0) begin
               mr = rsp_q.pop_front();
               chk("valid_owner", 128'(dc_rdat_m_valid), 128'(mr.own));
               chk("line_data", rdat_m_data, mr.data);
               chk("valid_cycle", 128'(cyc), 128'(mr.cyc));
            end
         end
         if (ic_finish_mrd || dc_finish_mrd) begin
            chk("finish_onehot", 128'(ic_finish_mrd & dc_finish_mrd), 128'h0);
            chk("fin_expected", 128'(fin_q.size() != 0), 128'h1);
            if (fin_q.size() != 0) begin
               mf = fin_q.pop_front();
               chk("finish_owner", 128'(dc_finish_mrd), 128'(mf.own));
               chk("finish_cycle", 128'(cyc), 128'(mf.cyc));
            end
         end
      end
   end

   initial begin
      int t, t2;
      rst_n = 1'b0;
      ic_start_rq = 1'b0; dc_start_rq = 1'b0;
      ic_rin_addr = 32'h0; dc_rin_addr = 32'h0;
      for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
      ram[14'h100] = 32'h11111111; ram[14'h101] = 32'h22222222;
      ram[14'h102] = 32'h33333333; ram[14'h103] = 32'h44444444;
      ram[14'h200] = 32'hA0000000; ram[14'h201] = 32'hA1111111;
      ram[14'h202] = 32'hA2222222; ram[14'h203] = 32'hA3333333;
      ram[14'h300] = 32'hC0000000; ram[14'h301] = 32'hC1111111;
      ram[14'h302] = 32'hC2222222; ram[14'h303] = 32'hC3333333;
      ram[14'h400] = 32'hB0000001; ram[14'h401] = 32'hB0000002;
      ram[14'h402] = 32'hB0000003; ram[14'h403] = 32'hB0000004;

      repeat (3) @(posedge clk); #1;
      chk("rst_busy", 128'(busy), 128'h0);
      chk("rst_data", rdat_m_data, 128'h0);
      chk("rst_ren", 128'(mem_ren), 128'h0);
      chk("rst_radr", 128'(mem_radr), 128'h0);
      chk("rst_valid", 128'({ic_rdat_m_valid, dc_rdat_m_valid}), 128'h0);
      chk("rst_finish", 128'({ic_finish_mrd, dc_finish_mrd}), 128'h0);
      rst_n = 1'b1;

      // Single IC read
      pulse(1'b1, 1'b0, 32'h0000_0400, 32'h0, t);
      push_line(1'b0, 14'h100, L1, t);
      repeat (8) @(posedge clk);

      // Address masking: upper and low nibble bits ignored
      pulse(1'b1, 1'b0, 32'hF000_040C, 32'h0, t);
      push_line(1'b0, 14'h100, L1, t);
      repeat (8) @(posedge clk);

      // Simultaneous: DC wins, IC follows
      pulse(1'b1, 1'b1, 32'h0000_0400, 32'h0000_0800, t);
      push_line(1'b1, 14'h200, LA, t);
      push_line(1'b0, 14'h100, L1, t + 8);
      repeat (16) @(posedge clk);

      // DC queued at T+3 during an IC transaction
      pulse(1'b1, 1'b0, 32'h0000_0400, 32'h0, t);
      push_line(1'b0, 14'h100, L1, t);
      @(posedge clk);
      pulse(1'b0, 1'b1, 32'h0, 32'h0000_0800, t2);
      push_line(1'b1, 14'h200, LA, t + 8);
      repeat (16) @(posedge clk);

      // Data hold while idle
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_data", rdat_m_data, LA);
      end
      chk("hold_busy", 128'(busy), 128'h0);

      // Reset in the middle of an IC read: only beats 0 and 1 are issued
      pulse(1'b1, 1'b0, 32'h0000_0C00, 32'h0, t);
      for (int k = 0; k < 2; k++) adr_q.push_back('{a: 14'h300 + 14'(k), cyc: t + 1 + k});
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 128'(busy), 128'h0);
      chk("midrst_data", rdat_m_data, 128'h0);
      chk("midrst_ren", 128'(mem_ren), 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk); #1;
      chk("midrst_idle", 128'(busy), 128'h0);
      chk("midrst_adr_drained", 128'(adr_q.size()), 128'h0);

      // Fresh request after reset
      pulse(1'b1, 1'b0, 32'h0000_1000, 32'h0, t);
      push_line(1'b0, 14'h400, LB, t);
      repeat (10) @(posedge clk); #1;

      chk("adr_q_empty", 128'(adr_q.size()), 128'h0);
      chk("rsp_q_empty", 128'(rsp_q.size()), 128'h0);
      chk("fin_q_empty", 128'(fin_q.size()), 128'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
